// File: rtl/regfile_writeback_queue.sv
// Write-side front end for the 32x32 register file.
// Writeback results are queued in order and retired one per cycle onto the
// single write port. Two lookup ports forward the newest pending value for a
// register, so operand readers never see stale register file contents.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_rd,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       wb_hold,
    input  logic                       flush,
    output logic                       wb_en,
    output logic [ADDR_W-1:0]          wb_reg,
    output logic [DATA_W-1:0]          wb_data,
    input  logic [ADDR_W-1:0]          lk1_reg,
    output logic                       lk1_hit,
    output logic [DATA_W-1:0]          lk1_data,
    input  logic [ADDR_W-1:0]          lk2_reg,
    output logic                       lk2_hit,
    output logic [DATA_W-1:0]          lk2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_vld;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   lk1_res;
    logic [DATA_W:0]   lk2_res;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    // No pass-through when full: a same-cycle retire does not open the input.
    assign in_ready = !full;

    // Writes to x0 complete the handshake but never occupy an entry.
    assign push = in_valid && in_ready && !flush && (in_rd != '0);
    assign pop  = wb_en;

    assign wb_en   = !empty && !wb_hold;
    assign wb_reg  = wb_en ? ent_rd[head]   : '0;
    assign wb_data = wb_en ? ent_data[head] : '0;

    // Pointer, occupancy and valid-bit bookkeeping; flush wins over enqueue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (push) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Entry payload storage; contents only matter while the valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[tail]   <= in_rd;
            ent_data[tail] <= in_data;
        end
    end

    // Walk entries oldest to newest so the newest match is the one kept.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] reg_addr);
        logic [DATA_W:0]  res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (reg_addr != '0 && ent_vld[idx] && ent_rd[idx] == reg_addr)
                res = {1'b1, ent_data[idx]};
        end
        return res;
    endfunction

    // Forwarding search for both lookup ports.
    always_comb begin
        lk1_res = lookup(lk1_reg);
        lk2_res = lookup(lk2_reg);
    end

    assign lk1_hit  = lk1_res[DATA_W];
    assign lk1_data = lk1_res[DATA_W-1:0];
    assign lk2_hit  = lk2_res[DATA_W];
    assign lk2_data = lk2_res[DATA_W-1:0];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: queue-based reference model, a per-cycle
// compare process, directed scenarios with literal expectations, random stream.
module tb_regfile_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              wb_hold;
    logic              flush;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] lk1_reg;
    logic              lk1_hit;
    logic [DATA_W-1:0] lk1_data;
    logic [ADDR_W-1:0] lk2_reg;
    logic              lk2_hit;
    logic [DATA_W-1:0] lk2_data;
    logic [2:0]        count;

    int n_checks = 0;
    int n_errors = 0;

    regfile_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .wb_hold(wb_hold), .flush(flush),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .lk1_reg(lk1_reg), .lk1_hit(lk1_hit), .lk1_data(lk1_data),
        .lk2_reg(lk2_reg), .lk2_hit(lk2_hit), .lk2_data(lk2_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Newest pending value for a register, or miss.
    function automatic logic [DATA_W:0] model_lookup(input logic [ADDR_W-1:0] r);
        if (r == 0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == r) return {1'b1, mq[i].d};
        return '0;
    endfunction

    // Reference model: in-order queue updated from the inputs seen at each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin
            int  sz;
            bit  rdy;
            bit  do_pop;
            sz     = mq.size();
            rdy    = (sz < DEPTH);
            do_pop = (sz > 0) && !wb_hold;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (in_valid && rdy && in_rd != 0) mq.push_back('{rd: in_rd, d: in_data});
            end
        end
    end

    // Compare every cycle, mid low phase, after inputs have settled.
    always @(negedge clk) begin
        logic              e_en;
        logic [DATA_W:0]   l1;
        logic [DATA_W:0]   l2;
        #2;
        e_en = (mq.size() > 0) && !wb_hold;
        l1   = model_lookup(lk1_reg);
        l2   = model_lookup(lk2_reg);
        chk("count",    32'(count),    32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("wb_en",    32'(wb_en),    32'(e_en));
        chk("wb_reg",   32'(wb_reg),   e_en ? 32'(mq[0].rd) : 32'd0);
        chk("wb_data",  wb_data,       e_en ? mq[0].d : 32'd0);
        chk("lk1_hit",  32'(lk1_hit),  32'(l1[DATA_W]));
        chk("lk1_data", lk1_data,      l1[DATA_W-1:0]);
        chk("lk2_hit",  32'(lk2_hit),  32'(l2[DATA_W]));
        chk("lk2_data", lk2_data,      l2[DATA_W-1:0]);
    end

    task automatic drive(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                         input logic hold, input logic fl);
        @(negedge clk);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        wb_hold  = hold;
        flush    = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_rd    = '0;
        in_data  = '0;
        wb_hold  = 1'b0;
        flush    = 1'b0;
        lk1_reg  = '0;
        lk2_reg  = '0;
        #1;
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_en",    32'(wb_en),    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single write: accepted at edge N, visible on the write port after it.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        chk("single_wb_en",   32'(wb_en),  32'd1);
        chk("single_wb_reg",  32'(wb_reg), 32'd5);
        chk("single_wb_data", wb_data,     32'hDEADBEEF);
        chk("single_count1",  32'(count),  32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        chk("single_count0",  32'(count),  32'd0);
        chk("single_wb_off",  32'(wb_en),  32'd0);

        // Fill under hold, stall a fifth push, then drain in order.
        for (int i = 1; i <= 4; i++) drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 1'b0);
        drive(1'b1, 5'd5, 32'h105, 1'b1, 1'b0);
        #3;
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_count",    32'(count),    32'd4);
        chk("fill_hold_en",  32'(wb_en),    32'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            #3;
            chk("fill_drain_reg",  32'(wb_reg), 32'(k));
            chk("fill_drain_data", wb_data,     32'h100 + 32'(k));
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        chk("fill_empty", 32'(count), 32'd0);

        // Forwarding: newest of two writes to x7 wins; x0 never hits.
        lk1_reg = 5'd7;
        lk2_reg = 5'd0;
        drive(1'b1, 5'd7, 32'h11, 1'b1, 1'b0);
        drive(1'b1, 5'd7, 32'h22, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 32'h99, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        #3;
        chk("fwd_lk1_hit",  32'(lk1_hit),  32'd1);
        chk("fwd_lk1_data", lk1_data,      32'h22);
        chk("fwd_lk2_hit",  32'(lk2_hit),  32'd0);
        chk("fwd_lk2_data", lk2_data,      32'd0);
        chk("fwd_count",    32'(count),    32'd2);
        idle(3);

        // Flush with a concurrent enqueue: everything gone after the edge.
        lk1_reg = 5'd3;
        lk2_reg = 5'd9;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 1'b0);
        drive(1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 1'b0);
        drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
        #3;
        chk("flush_pre_count", 32'(count),   32'd3);
        chk("flush_pre_hit",   32'(lk1_hit), 32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        chk("flush_count",   32'(count),   32'd0);
        chk("flush_lk1_hit", 32'(lk1_hit), 32'd0);
        chk("flush_lk2_hit", 32'(lk2_hit), 32'd0);

        // Asynchronous reset mid-stream with three entries queued.
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 1'b0);
        drive(1'b1, 5'd2, 32'hA2, 1'b1, 1'b0);
        drive(1'b1, 5'd3, 32'hA3, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("mid_pre_count", 32'(count), 32'd3);
        chk("mid_pre_wb_en", 32'(wb_en), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_count",    32'(count),    32'd0);
        chk("mid_rst_wb_en",    32'(wb_en),    32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_lk1",      32'(lk1_hit),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Random stream: small register range so forwarding and duplicates occur.
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 99) < 70,
                  5'($urandom_range(0, 7)),
                  $urandom(),
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 4);
            lk1_reg = 5'($urandom_range(0, 7));
            lk2_reg = 5'($urandom_range(0, 7));
        end
        idle(6);
        #3;
        chk("final_empty", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
